issueque_int: RTL and testbench
===============================

Name: issueque_int

Overview:
- Integer issue queue sitting directly upstream of the issue unit.
- Accepts dispatched integer ops with operand values or producer tags, and snoops the CDB to wake up waiting operands.
- Selects the oldest ready entry and presents it on the issueint_* interface.
- Removes that entry when the issue unit returns issueint_equeueint_done.

Parameters:
DEPTH, 4, number of queue entries; any value from 2 to 8.
TAGW, 6, width of physical/ROB tags.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
dispatch_en  in  1  write one new op this cycle.
dispatch_opcode  in  6  ALU opcode.
dispatch_rsdata  in  32  rs value; meaningful when dispatch_rsvalid=1.
dispatch_rsvalid  in  1  rs value present.
dispatch_rstag  in  TAGW  rs producer tag; meaningful when dispatch_rsvalid=0.
dispatch_rtdata  in  32  rt value.
dispatch_rtvalid  in  1  rt value present.
dispatch_rttag  in  TAGW  rt producer tag.
dispatch_rdtag  in  TAGW  destination tag.
flush  in  1  synchronous clear of all entries (branch mispredict).
cdb_valid  in  1  CDB broadcast valid.
cdb_tag  in  TAGW  CDB tag.
cdb_data  in  32  CDB data.
issueint_equeueint_done  in  1  issue unit accepted the presented entry this cycle.
issueque_full  out  1  no free entry.
issueint_ready  out  1  a ready entry is presented.
issueint_opcode  out  6  presented opcode.
issueint_rsdata  out  32  presented rs value.
issueint_rtdata  out  32  presented rt value.
issueint_rdtag  out  TAGW  presented destination tag.

Behaviour:
- Storage:
  - DEPTH entries, each holding valid, opcode, rsdata, rsvalid, rstag, rtdata, rtvalid, rttag and rdtag.
  - Entries are kept age-ordered and compacted: index 0 is the oldest, and valid entries occupy indices 0..count-1.
  - Count is kept as a registered counter, 0..DEPTH.
- Reset (reset=0):
  - All entry valid bits clear and count=0, asynchronously.
  - issueque_full=0 and issueint_ready=0.
  - issueint_opcode, issueint_rsdata, issueint_rtdata and issueint_rdtag read 0.
- Ready and select:
  - An entry is ready when valid & rsvalid & rtvalid, using registered state only.
  - Select is the lowest-index ready entry, combinational from registers.
  - issueint_* outputs show the selected entry; they are all-zero when no entry is ready.
  - Zero-latency presentation: an op whose last operand was captured at edge N can be presented in cycle N+1 at the earliest.
  - An operand arriving on the CDB in the same cycle does not make an entry ready that cycle.
- Dequeue:
  - issueint_equeueint_done is sampled only when issueint_ready=1; when ready=0 it is ignored.
  - At the edge, the selected entry is removed, entries above it shift down by one, and count decrements.
- Wakeup:
  - Every cycle with cdb_valid=1, each valid entry compares rstag and rttag against cdb_tag where the corresponding valid bit is 0.
  - On a match it writes cdb_data and sets the valid bit.
  - Wakeup is applied to the post-shift position of the entry.
- Dispatch:
  - When dispatch_en=1 and issueque_full=0, the new op is written at index count, or count-1 if a dequeue occurs in the same cycle.
  - Dispatch forwarding: if a dispatch operand is not valid and its tag matches a valid CDB broadcast in the same cycle, the entry is written with the CDB data and the operand marked valid.
  - When dispatch_en=1 and issueque_full=1, the dispatch is dropped even if a dequeue happens in the same cycle. Upstream must stall on full.
- issueque_full is registered and equals (count==DEPTH) after each edge.
- flush=1:
  - At the edge, all entries are cleared and count=0.
  - Any dispatch or dequeue in the same cycle is discarded; flush has priority.
  - issueint_ready may still be 1 during the flush cycle; the issue unit's completion of that op is the ROB's concern.
- Simultaneous dispatch + dequeue + wakeup in one cycle: all three take effect with no loss, and count is unchanged.
- Reset asserted mid-operation: behaves as reset; no partial state survives.

Test Plan:
- Ready dispatch: dispatch op 0x20 with rs=5 and rt=7, both valid, rdtag=3 → next cycle issueint_ready=1, opcode=0x20, rsdata=5, rtdata=7, rdtag=3. With done=1, the queue is empty and ready=0 the following cycle.
- Wakeup: dispatch with rs waiting on tag 9. Broadcast cdb_valid=1, tag=9, data=0xDEADBEEF → ready=0 in the broadcast cycle, then ready=1 with rsdata=0xDEADBEEF next cycle. A broadcast with tag 10 has no effect.
- Dispatch-cycle forwarding: dispatch rt waiting on tag 12 while the CDB carries tag 12, data=0x55 → entry is ready the next cycle with rtdata=0x55.
- Age order and compaction: fill 4 entries where entry0 waits and entries 1–3 are ready → entry1 is presented. Dequeue it and then dispatch → count=4, full=1, and entries 2 and 3 are presented in order. A dispatch while full is dropped.
- Simultaneous events at full: 4 entries, done=1 plus dispatch_en=1 → dispatch is dropped and count=3. The same at count=3 gives count=3 with the new op at index 2.
- Flush and reset: flush with 3 entries plus a concurrent dispatch → count=0, full=0, ready=0. Assert reset low asynchronously mid-cycle → all outputs go to 0 immediately.

Source files
------------

// File: rtl/issueque_int.sv
// Integer issue queue: age-ordered, compacted entries with CDB wakeup and oldest-ready select.
// Presents combinationally from registers; the entry is removed at the edge where done && ready.
module issueque_int #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dispatch_en,
    input  logic [5:0]      dispatch_opcode,
    input  logic [31:0]     dispatch_rsdata,
    input  logic            dispatch_rsvalid,
    input  logic [TAGW-1:0] dispatch_rstag,
    input  logic [31:0]     dispatch_rtdata,
    input  logic            dispatch_rtvalid,
    input  logic [TAGW-1:0] dispatch_rttag,
    input  logic [TAGW-1:0] dispatch_rdtag,
    input  logic            flush,
    input  logic            cdb_valid,
    input  logic [TAGW-1:0] cdb_tag,
    input  logic [31:0]     cdb_data,
    input  logic            issueint_equeueint_done,
    output logic            issueque_full,
    output logic            issueint_ready,
    output logic [5:0]      issueint_opcode,
    output logic [31:0]     issueint_rsdata,
    output logic [31:0]     issueint_rtdata,
    output logic [TAGW-1:0] issueint_rdtag
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic            valid;
        logic [5:0]      opcode;
        logic [31:0]     rsdata;
        logic            rsvalid;
        logic [TAGW-1:0] rstag;
        logic [31:0]     rtdata;
        logic            rtvalid;
        logic [TAGW-1:0] rttag;
        logic [TAGW-1:0] rdtag;
    } entry_t;

    entry_t        q     [DEPTH];
    entry_t        q_nxt [DEPTH];
    entry_t        new_e;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] widx;
    logic [IW-1:0] sel;
    logic          any_rdy;
    logic          deq;
    logic          disp;
    logic          full_r;
    logic          full_nxt;

    // Scanning from the top down leaves the lowest-index ready entry in sel.
    always_comb begin
        any_rdy = 1'b0;
        sel     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].rsvalid && q[i].rtvalid) begin
                any_rdy = 1'b1;
                sel     = IW'(i);
            end
        end
    end

    always_comb begin
        issueint_ready  = any_rdy;
        issueint_opcode = '0;
        issueint_rsdata = '0;
        issueint_rtdata = '0;
        issueint_rdtag  = '0;
        if (any_rdy) begin
            issueint_opcode = q[sel].opcode;
            issueint_rsdata = q[sel].rsdata;
            issueint_rtdata = q[sel].rtdata;
            issueint_rdtag  = q[sel].rdtag;
        end
    end

    assign deq           = issueint_equeueint_done & any_rdy;
    assign disp          = dispatch_en & ~full_r;
    assign widx          = count - CW'(deq);
    assign issueque_full = full_r;

    // New entry, with operands forwarded from a same-cycle CDB broadcast.
    always_comb begin
        new_e         = '0;
        new_e.valid   = 1'b1;
        new_e.opcode  = dispatch_opcode;
        new_e.rdtag   = dispatch_rdtag;
        new_e.rsdata  = dispatch_rsdata;
        new_e.rsvalid = dispatch_rsvalid;
        new_e.rstag   = dispatch_rstag;
        new_e.rtdata  = dispatch_rtdata;
        new_e.rtvalid = dispatch_rtvalid;
        new_e.rttag   = dispatch_rttag;
        if (!dispatch_rsvalid && cdb_valid && (cdb_tag == dispatch_rstag)) begin
            new_e.rsdata  = cdb_data;
            new_e.rsvalid = 1'b1;
        end
        if (!dispatch_rtvalid && cdb_valid && (cdb_tag == dispatch_rttag)) begin
            new_e.rtdata  = cdb_data;
            new_e.rtvalid = 1'b1;
        end
    end

    // Order matters: compact first, then wake the shifted entries, then append.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            q_nxt[i] = (deq && (i >= int'(sel))) ? q[i + 1] : q[i];
        end
        q_nxt[DEPTH - 1] = deq ? entry_t'('0) : q[DEPTH - 1];

        for (int i = 0; i < DEPTH; i++) begin
            if (q_nxt[i].valid && cdb_valid) begin
                if (!q_nxt[i].rsvalid && (q_nxt[i].rstag == cdb_tag)) begin
                    q_nxt[i].rsdata  = cdb_data;
                    q_nxt[i].rsvalid = 1'b1;
                end
                if (!q_nxt[i].rtvalid && (q_nxt[i].rttag == cdb_tag)) begin
                    q_nxt[i].rtdata  = cdb_data;
                    q_nxt[i].rtvalid = 1'b1;
                end
            end
            if (disp && (i == int'(widx))) begin
                q_nxt[i] = new_e;
            end
        end

        count_nxt = count + CW'(disp) - CW'(deq);

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_nxt[i] = '0;
            end
            count_nxt = '0;
        end
        full_nxt = (count_nxt == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
            count  <= '0;
            full_r <= 1'b0;
        end else begin
            q      <= q_nxt;
            count  <= count_nxt;
            full_r <= full_nxt;
        end
    end
endmodule

// File: tb/tb_issueque_int.sv
// Directed bench for issueque_int; issued ops are checked against a scoreboard of expected ops.
module tb_issueque_int;
    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_en;
    logic [5:0]  dispatch_opcode;
    logic [31:0] dispatch_rsdata;
    logic        dispatch_rsvalid;
    logic [5:0]  dispatch_rstag;
    logic [31:0] dispatch_rtdata;
    logic        dispatch_rtvalid;
    logic [5:0]  dispatch_rttag;
    logic [5:0]  dispatch_rdtag;
    logic        flush;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        done;
    logic        issueque_full;
    logic        issueint_ready;
    logic [5:0]  issueint_opcode;
    logic [31:0] issueint_rsdata;
    logic [31:0] issueint_rtdata;
    logic [5:0]  issueint_rdtag;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    issueque_int #(.DEPTH(4), .TAGW(6)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .dispatch_en             (dispatch_en),
        .dispatch_opcode         (dispatch_opcode),
        .dispatch_rsdata         (dispatch_rsdata),
        .dispatch_rsvalid        (dispatch_rsvalid),
        .dispatch_rstag          (dispatch_rstag),
        .dispatch_rtdata         (dispatch_rtdata),
        .dispatch_rtvalid        (dispatch_rtvalid),
        .dispatch_rttag          (dispatch_rttag),
        .dispatch_rdtag          (dispatch_rdtag),
        .flush                   (flush),
        .cdb_valid               (cdb_valid),
        .cdb_tag                 (cdb_tag),
        .cdb_data                (cdb_data),
        .issueint_equeueint_done (done),
        .issueque_full           (issueque_full),
        .issueint_ready          (issueint_ready),
        .issueint_opcode         (issueint_opcode),
        .issueint_rsdata         (issueint_rsdata),
        .issueint_rtdata         (issueint_rtdata),
        .issueint_rdtag          (issueint_rdtag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic idle();
        dispatch_en      = 1'b0;
        dispatch_opcode  = '0;
        dispatch_rsdata  = '0;
        dispatch_rsvalid = 1'b0;
        dispatch_rstag   = '0;
        dispatch_rtdata  = '0;
        dispatch_rtvalid = 1'b0;
        dispatch_rttag   = '0;
        dispatch_rdtag   = '0;
        flush            = 1'b0;
        cdb_valid        = 1'b0;
        cdb_tag          = '0;
        cdb_data         = '0;
        done             = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] rs, input logic rsv,
                        input logic [5:0] rstag, input logic [31:0] rt, input logic rtv,
                        input logic [5:0] rttag, input logic [5:0] rd);
        dispatch_en      = 1'b1;
        dispatch_opcode  = op;
        dispatch_rsdata  = rs;
        dispatch_rsvalid = rsv;
        dispatch_rstag   = rstag;
        dispatch_rtdata  = rt;
        dispatch_rtvalid = rtv;
        dispatch_rttag   = rttag;
        dispatch_rdtag   = rd;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    // Pushes the op expected at the head of issue and asserts done for this cycle.
    task automatic take(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [5:0] rd);
        exp_t e;
        e.op = op; e.rs = rs; e.rt = rt; e.rd = rd;
        sb.push_back(e);
        done = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (issueint_ready && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_issue_opcode", 32'(issueint_opcode), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("issue_opcode", 32'(issueint_opcode), 32'(e.op));
                    chk("issue_rsdata", issueint_rsdata, e.rs);
                    chk("issue_rtdata", issueint_rtdata, e.rt);
                    chk("issue_rdtag", 32'(issueint_rdtag), 32'(e.rd));
                end
            end
        end
    endtask

    task automatic stimulus();
        // Reset state
        #2;
        chk("rst_ready", 32'(issueint_ready), 32'd0);
        chk("rst_full", 32'(issueque_full), 32'd0);
        chk("rst_opcode", 32'(issueint_opcode), 32'd0);
        chk("rst_rdtag", 32'(issueint_rdtag), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Ready dispatch, issue, empty
        disp(6'h20, 32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd3);
        cycle();
        chk("rdy_after_dispatch", 32'(issueint_ready), 32'd1);
        take(6'h20, 32'd5, 32'd7, 6'd3);
        cycle();
        chk("empty_after_issue", 32'(issueint_ready), 32'd0);

        // Wakeup; non-matching tag has no effect; no same-cycle readiness
        disp(6'h21, 32'd0, 1'b0, 6'd9, 32'd1, 1'b1, 6'd0, 6'd4);
        cycle();
        chk("wait_not_ready", 32'(issueint_ready), 32'd0);
        cdb(6'd10, 32'h1111_1111);
        cycle();
        chk("wrong_tag_no_wake", 32'(issueint_ready), 32'd0);
        cdb(6'd9, 32'hDEAD_BEEF);
        #1;
        chk("bcast_cycle_not_ready", 32'(issueint_ready), 32'd0);
        cycle();
        chk("woken_ready", 32'(issueint_ready), 32'd1);
        take(6'h21, 32'hDEAD_BEEF, 32'd1, 6'd4);
        cycle();

        // Dispatch-cycle forwarding
        disp(6'h22, 32'hA, 1'b1, 6'd0, 32'd0, 1'b0, 6'd12, 6'd5);
        cdb(6'd12, 32'h55);
        cycle();
        chk("fwd_ready", 32'(issueint_ready), 32'd1);
        take(6'h22, 32'hA, 32'h55, 6'd5);
        cycle();

        // Age order: e0 waits on tag 20, e1..e3 ready
        disp(6'h30, 32'd0, 1'b0, 6'd20, 32'd1, 1'b1, 6'd0, 6'd10); cycle();
        disp(6'h31, 32'h11, 1'b1, 6'd0, 32'h12, 1'b1, 6'd0, 6'd11); cycle();
        disp(6'h32, 32'h21, 1'b1, 6'd0, 32'h22, 1'b1, 6'd0, 6'd12); cycle();
        disp(6'h33, 32'h31, 1'b1, 6'd0, 32'h32, 1'b1, 6'd0, 6'd13); cycle();
        chk("full_at_4", 32'(issueque_full), 32'd1);
        take(6'h31, 32'h11, 32'h12, 6'd11);
        cycle();
        chk("not_full_at_3", 32'(issueque_full), 32'd0);
        disp(6'h34, 32'h41, 1'b1, 6'd0, 32'h42, 1'b1, 6'd0, 6'd14);
        cycle();
        chk("refull", 32'(issueque_full), 32'd1);
        disp(6'h35, 32'h51, 1'b1, 6'd0, 32'h52, 1'b1, 6'd0, 6'd15);
        cycle();
        chk("full_drop", 32'(issueque_full), 32'd1);
        // Dequeue + dispatch at full: dispatch dropped, count 3
        take(6'h32, 32'h21, 32'h22, 6'd12);
        disp(6'h36, 32'h61, 1'b1, 6'd0, 32'h62, 1'b1, 6'd0, 6'd16);
        cycle();
        chk("full_deq_disp_drop", 32'(issueque_full), 32'd0);
        // Dequeue + dispatch at 3: count stays 3
        take(6'h33, 32'h31, 32'h32, 6'd13);
        disp(6'h37, 32'h71, 1'b1, 6'd0, 32'h72, 1'b1, 6'd0, 6'd17);
        cycle();
        chk("deq_disp_at3", 32'(issueque_full), 32'd0);
        // Dispatch + dequeue + wakeup together
        take(6'h34, 32'h41, 32'h42, 6'd14);
        disp(6'h38, 32'h81, 1'b1, 6'd0, 32'h82, 1'b1, 6'd0, 6'd18);
        cdb(6'd20, 32'hA0);
        cycle();
        chk("triple_not_full", 32'(issueque_full), 32'd0);
        take(6'h30, 32'hA0, 32'd1, 6'd10); cycle();
        take(6'h37, 32'h71, 32'h72, 6'd17); cycle();
        take(6'h38, 32'h81, 32'h82, 6'd18); cycle();
        chk("drained_ready", 32'(issueint_ready), 32'd0);

        // Flush with concurrent dispatch and dequeue
        disp(6'h01, 32'd1, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd21); cycle();
        disp(6'h02, 32'd3, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 6'd22); cycle();
        disp(6'h03, 32'd5, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 6'd23); cycle();
        chk("pre_flush_ready", 32'(issueint_ready), 32'd1);
        take(6'h01, 32'd1, 32'd2, 6'd21);
        disp(6'h04, 32'd7, 1'b1, 6'd0, 32'd8, 1'b1, 6'd0, 6'd24);
        flush = 1'b1;
        cycle();
        chk("flush_ready", 32'(issueint_ready), 32'd0);
        chk("flush_full", 32'(issueque_full), 32'd0);
        cycle();
        chk("flush_disp_discarded", 32'(issueint_ready), 32'd0);

        // Asynchronous reset mid-cycle at full
        for (int k = 0; k < 4; k++) begin
            disp(6'(8'h10 + k), 32'(k), 1'b1, 6'd0, 32'(k + 1), 1'b1, 6'd0, 6'(k));
            cycle();
        end
        chk("pre_reset_full", 32'(issueque_full), 32'd1);
        chk("pre_reset_opcode", 32'(issueint_opcode), 32'h10);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ready", 32'(issueint_ready), 32'd0);
        chk("arst_full", 32'(issueque_full), 32'd0);
        chk("arst_opcode", 32'(issueint_opcode), 32'd0);
        chk("arst_rsdata", issueint_rsdata, 32'd0);
        chk("arst_rtdata", issueint_rtdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cycle();
        chk("post_reset_ready", 32'(issueint_ready), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        fork
            monitor();
            stimulus();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
